// File: rtl/ahb_trace_pkg.sv
// Shared constants for the AHB address trace block.
// Entry layout, marker encoding, FSM states and HTRANS codes.
package ahb_trace_pkg;

  localparam int ADDR_LSB     = 0;
  localparam int WRITE_BIT    = 32;
  localparam int SIZE_LSB     = 33;
  localparam int TS_LSB       = 36;
  localparam int ENTRY_BASE_W = 36;
  localparam int TS_W_DEF     = 16;
  localparam int ENTRY_W      = ENTRY_BASE_W + TS_W_DEF;

  localparam logic [2:0] MARKER_SIZE   = 3'b111;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DROP = 2'd2
  } state_e;

endpackage

// File: rtl/ahb_addr_trace_if.sv
// AHB address-phase snoop signals plus the trace drain stream.
// slave = trace block view, master = bus/consumer view.
interface ahb_addr_trace_if #(
  parameter int TS_W  = 16,
  parameter int DEPTH = 16
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic [31:0]      HADDR;
  logic [1:0]       HTRANS;
  logic [2:0]       HSIZE;
  logic             HWRITE;
  logic             HREADY;
  logic             trc_valid;
  logic [35+TS_W:0] trc_data;
  logic             trc_ready;
  logic [LVL_W-1:0] trc_level;

  modport slave (
    input  HADDR, HTRANS, HSIZE, HWRITE, HREADY,
    input  trc_ready,
    output trc_valid, trc_data, trc_level
  );

  modport master (
    output HADDR, HTRANS, HSIZE, HWRITE, HREADY,
    output trc_ready,
    input  trc_valid, trc_data, trc_level
  );

endinterface

// File: rtl/ahb_trace_fifo.sv
// DEPTH x W trace FIFO with registered head and occupancy.
// A pop frees the slot in the same cycle, so push-when-full+pop is accepted.
module ahb_trace_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 52,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             HCLK,
  input  logic             HRESET,
  input  logic             push,
  input  logic [W-1:0]     din,
  input  logic             pop,
  output logic [W-1:0]     dout,
  output logic             valid,
  output logic [LVL_W-1:0] level,
  output logic             full
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [LVL_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign valid   = cnt_q != '0;
  assign full    = cnt_q == LVL_W'(DEPTH);
  assign level   = cnt_q;
  assign dout    = mem_q[rd_q];
  assign do_pop  = pop & valid;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q + LVL_W'(do_push) - LVL_W'(do_pop);
    if (do_push) begin
      mem_d[wr_q] = din;
      wr_d        = wr_q + 1'b1;
    end
    if (do_pop) rd_d = rd_q + 1'b1;
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      mem_q <= '{default: '0};
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ahb_addr_trace.sv
// AHB address-phase trace: window filter, cycle-delta stamp, FIFO,
// and an in-band marker counting transfers lost while the FIFO was full.
module ahb_addr_trace
  import ahb_trace_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int TS_W  = 16
) (
  input  logic              HCLK,
  input  logic              HRESET,
  ahb_addr_trace_if.slave   bus,
  input  logic              cfg_en,
  input  logic [31:0]       cfg_lo,
  input  logic [31:0]       cfg_hi,
  output logic              ovf,
  input  logic              ovf_clr
);
  localparam int EW    = ENTRY_BASE_W + TS_W;
  localparam int LVL_W = $clog2(DEPTH) + 1;

  state_e           state_q, state_d;
  logic [TS_W-1:0]  ts_q, ts_d, ts_inc;
  logic [15:0]      drop_q, drop_d, drop_inc;
  logic             ovf_q, ovf_d;
  logic             is_xfer, hit, push, pop, can_push;
  logic             full, valid;
  logic [EW-1:0]    din, dout;
  logic [LVL_W-1:0] level;

  assign is_xfer = (bus.HTRANS == HTRANS_NONSEQ) |
                   (bus.HTRANS == HTRANS_SEQ);
  assign hit = cfg_en & bus.HREADY & is_xfer &
               (bus.HADDR >= cfg_lo) & (bus.HADDR <= cfg_hi);

  assign pop      = valid & bus.trc_ready;
  assign can_push = ~full | pop;
  assign ts_inc   = (&ts_q) ? ts_q : ts_q + 1'b1;
  // Same-cycle hit is folded into the count carried by the marker.
  assign drop_inc = (hit & ~(&drop_q)) ? drop_q + 16'd1 : drop_q;

  always_comb begin
    state_d = state_q;
    ts_d    = ts_q;
    drop_d  = drop_q;
    ovf_d   = ovf_q & ~ovf_clr;
    push    = 1'b0;
    din     = '0;
    din[TS_LSB +: TS_W] = ts_q;
    unique case (state_q)
      IDLE: begin
        ts_d = '0;
        if (cfg_en) state_d = RUN;
      end
      RUN: begin
        ts_d = ts_inc;
        if (hit && can_push) begin
          push = 1'b1;
          din[ADDR_LSB +: 32] = bus.HADDR;
          din[WRITE_BIT]      = bus.HWRITE;
          din[SIZE_LSB +: 3]  = bus.HSIZE;
        end else if (hit) begin
          drop_d  = 16'd1;
          ovf_d   = 1'b1;
          state_d = DROP;
        end
      end
      DROP: begin
        ts_d = ts_inc;
        if (hit) ovf_d = 1'b1;
        if (can_push) begin
          push = 1'b1;
          din[ADDR_LSB +: 32] = {16'h0, drop_inc};
          din[SIZE_LSB +: 3]  = MARKER_SIZE;
          drop_d  = '0;
          state_d = RUN;
        end else begin
          drop_d = drop_inc;
        end
      end
      default: state_d = IDLE;
    endcase
    if (push) ts_d = TS_W'(1);
    // Disable discards any pending marker; FIFO keeps its contents.
    if (!cfg_en) begin
      state_d = IDLE;
      drop_d  = '0;
      push    = 1'b0;
      ts_d    = '0;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q <= IDLE;
      ts_q    <= '0;
      drop_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ts_q    <= ts_d;
      drop_q  <= drop_d;
      ovf_q   <= ovf_d;
    end
  end

  ahb_trace_fifo #(
    .DEPTH(DEPTH),
    .W    (EW)
  ) u_fifo (
    .HCLK  (HCLK),
    .HRESET(HRESET),
    .push  (push),
    .din   (din),
    .pop   (pop),
    .dout  (dout),
    .valid (valid),
    .level (level),
    .full  (full)
  );

  assign bus.trc_valid = valid;
  assign bus.trc_data  = dout;
  assign bus.trc_level = level;
  assign ovf           = ovf_q;

endmodule
